// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one unsigned multiplier among NUM_REQ requesters.
// Grant is combinational; the product returns two cycles after the transfer.
module multiplier_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH_1 = 16,
   parameter int DATA_WIDTH_2 = 16,
   parameter int ID_WIDTH     = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   input  logic [NUM_REQ*DATA_WIDTH_1-1:0]    data1_i,
   input  logic [NUM_REQ*DATA_WIDTH_2-1:0]    data2_i,
   output logic                               res_valid_o,
   output logic [ID_WIDTH-1:0]                res_id_o,
   output logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] data_o
);

   localparam int PW = DATA_WIDTH_1 + DATA_WIDTH_2;

   logic [ID_WIDTH-1:0]     r_ptr;
   logic [ID_WIDTH-1:0]     w_idx;
   logic [ID_WIDTH-1:0]     w_gnt_id;
   logic [ID_WIDTH-1:0]     w_ptr_nxt;
   logic                    w_hit;
   logic                    w_found;
   logic                    w_xfer;
   logic [NUM_REQ-1:0]      w_gnt;
   logic [DATA_WIDTH_1-1:0] w_op1;
   logic [DATA_WIDTH_2-1:0] w_op2;
   logic [PW-1:0]           w_prod;

   logic                    r_s1_valid;
   logic [ID_WIDTH-1:0]     r_s1_id;
   logic [DATA_WIDTH_1-1:0] r_s1_op1;
   logic [DATA_WIDTH_2-1:0] r_s1_op2;
   logic                    r_res_valid;
   logic [ID_WIDTH-1:0]     r_res_id;
   logic [PW-1:0]           r_data;

   // Search from the pointer upward, modulo NUM_REQ, for the first valid requester.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      w_idx    = '0;
      w_hit    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx    = ID_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
         w_hit    = !w_found && req_valid_i[w_idx];
         w_gnt_id = w_hit ? w_idx : w_gnt_id;
         w_found  = w_found | w_hit;
      end
   end

   // Grant vector, pointer successor and operand selection for the winner.
   always_comb begin
      w_xfer    = w_found & ~rst_i;
      w_gnt     = w_xfer ? (NUM_REQ'(1) << w_gnt_id) : '0;
      w_ptr_nxt = (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_WIDTH'(1);
      w_op1     = data1_i[w_gnt_id*DATA_WIDTH_1 +: DATA_WIDTH_1];
      w_op2     = data2_i[w_gnt_id*DATA_WIDTH_2 +: DATA_WIDTH_2];
      w_prod    = PW'(r_s1_op1) * PW'(r_s1_op2);
   end

   // Pointer, operand stage and result stage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr       <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_id     <= '0;
         r_s1_op1    <= '0;
         r_s1_op2    <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_data      <= '0;
      end else begin
         r_s1_valid  <= w_xfer;
         r_res_valid <= r_s1_valid;
         if (w_xfer) begin
            r_ptr    <= w_ptr_nxt;
            r_s1_id  <= w_gnt_id;
            r_s1_op1 <= w_op1;
            r_s1_op2 <= w_op2;
         end
         // Result registers only move when a product is actually delivered.
         if (r_s1_valid) begin
            r_data   <= w_prod;
            r_res_id <= r_s1_id;
         end
      end
   end

   assign req_ready_o = w_gnt;
   assign res_valid_o = r_res_valid;
   assign res_id_o    = r_res_id;
   assign data_o      = r_data;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Scoreboard bench for multiplier_arbiter: driver predicts grants and pushes
// expected products; a negedge monitor pops and checks every result pulse.
module tb_multiplier_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = 4'd0;
   logic [3:0]  req_ready;
   logic [63:0] data1 = 64'd0;
   logic [63:0] data2 = 64'd0;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [31:0] data_o;

   multiplier_arbiter #(
      .NUM_REQ(4), .DATA_WIDTH_1(16), .DATA_WIDTH_2(16), .ID_WIDTH(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .data1_i(data1), .data2_i(data2), .res_valid_o(res_valid),
      .res_id_o(res_id), .data_o(data_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      logic [31:0] prod;
      int          due;
   } exp_t;

   exp_t        sb[$];
   exp_t        e_m;
   int          checks = 0;
   int          passed = 0;
   logic [31:0] hold_data = 32'd0;
   int          hold_id = 0;
   int          mptr = 0;
   logic        prev_r = 1'b1;
   logic [3:0]  last_gnt = 4'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [63:0] pack4(input logic [15:0] a0, input logic [15:0] a1,
                                         input logic [15:0] a2, input logic [15:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   // One cycle of stimulus plus the grant prediction for that cycle.
   task automatic drive(input logic [3:0] v, input logic [63:0] d1, input logic [63:0] d2,
                        input logic r);
      logic [3:0] eg;
      int gid;
      @(posedge clk);
      #1;
      if (prev_r) begin
         hold_data = 32'd0;
         hold_id   = 0;
      end
      rst = r; req_valid = v; data1 = d1; data2 = d2;
      if (r) begin
         mptr = 0;
         while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      end
      @(negedge clk);
      if (prev_r) begin
         check("reset res_valid", {63'd0, res_valid}, 64'd0);
         check("reset data_o", {32'd0, data_o}, 64'd0);
         check("reset res_id", {62'd0, res_id}, 64'd0);
      end
      eg  = 4'd0;
      gid = -1;
      if (!r) begin
         for (int i = 0; i < 4; i++) begin
            if (gid < 0 && v[(mptr + i) % 4]) gid = (mptr + i) % 4;
         end
      end
      if (gid >= 0) eg[gid] = 1'b1;
      check("grant", {60'd0, req_ready}, {60'd0, eg});
      if (gid >= 0) begin
         sb.push_back('{gid, 32'(d1[gid*16 +: 16]) * 32'(d2[gid*16 +: 16]), cyc + 2});
         mptr = (gid + 1) % 4;
      end
      last_gnt = eg;
      prev_r   = r;
   endtask

   // Monitor: every pulse must match the oldest prediction, on time; otherwise outputs hold.
   always @(negedge clk) begin
      if (res_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected result: got id %0d data 0x%0h, expected none (cycle %0d)",
                     res_id, data_o, cyc);
         end else begin
            e_m = sb.pop_front();
            check("res_id", {62'd0, res_id}, 64'(e_m.id));
            check("data_o", {32'd0, data_o}, {32'd0, e_m.prod});
            check("latency", 64'(cyc), 64'(e_m.due));
            hold_data = e_m.prod;
            hold_id   = e_m.id;
         end
      end else begin
         check("hold data_o", {32'd0, data_o}, {32'd0, hold_data});
         check("hold res_id", {62'd0, res_id}, 64'(hold_id));
         if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            $display("FAIL missing result: got none, expected id %0d data 0x%0h (cycle %0d)",
                     sb[0].id, sb[0].prod, cyc);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0]  cv;
      logic [63:0] cd1, cd2;
      logic [15:0] rv;
      logic        rr;

      drive(4'd0, 64'd0, 64'd0, 1'b1);
      drive(4'd0, 64'd0, 64'd0, 1'b1);

      // single request 3*5
      drive(4'b0001, pack4(16'd3, 16'd0, 16'd0, 16'd0), pack4(16'd5, 16'd0, 16'd0, 16'd0), 1'b0);
      repeat (4) drive(4'd0, 64'd0, 64'd0, 1'b0);

      // full-width product from requester 2
      drive(4'b0100, pack4(16'd0, 16'd0, 16'hFFFF, 16'd0), pack4(16'd0, 16'd0, 16'hFFFF, 16'd0), 1'b0);
      repeat (3) drive(4'd0, 64'd0, 64'd0, 1'b0);

      // round-robin with all four requesters continuously valid
      drive(4'd0, 64'd0, 64'd0, 1'b1);
      repeat (8) drive(4'b1111, pack4(16'd1, 16'd2, 16'd3, 16'd4),
                       pack4(16'd10, 16'd11, 16'd12, 16'd13), 1'b0);
      repeat (3) drive(4'd0, 64'd0, 64'd0, 1'b0);

      // pointer wrap and skip of idle requester 2
      drive(4'd0, 64'd0, 64'd0, 1'b1);
      drive(4'b0100, pack4(16'd0, 16'd0, 16'd7, 16'd0), pack4(16'd0, 16'd0, 16'd9, 16'd0), 1'b0);
      repeat (3) drive(4'b1011, pack4(16'd21, 16'd22, 16'd0, 16'd23),
                       pack4(16'd31, 16'd32, 16'd0, 16'd33), 1'b0);
      repeat (3) drive(4'd0, 64'd0, 64'd0, 1'b0);

      // reset while an operation is in flight
      drive(4'b0010, pack4(16'd0, 16'd100, 16'd0, 16'd0), pack4(16'd0, 16'd3, 16'd0, 16'd0), 1'b0);
      drive(4'b0010, pack4(16'd0, 16'd200, 16'd0, 16'd0), pack4(16'd0, 16'd4, 16'd0, 16'd0), 1'b0);
      drive(4'b1111, pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd5, 16'd6, 16'd7, 16'd8), 1'b1);
      drive(4'b1111, pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd5, 16'd6, 16'd7, 16'd8), 1'b0);
      repeat (3) drive(4'd0, 64'd0, 64'd0, 1'b0);

      // requester 1 withdraws after losing arbitration
      drive(4'd0, 64'd0, 64'd0, 1'b1);
      drive(4'b0011, pack4(16'd11, 16'd12, 16'd0, 16'd0), pack4(16'd13, 16'd14, 16'd0, 16'd0), 1'b0);
      repeat (5) drive(4'd0, 64'd0, 64'd0, 1'b0);

      // randomized traffic: stalled requesters hold operands, may withdraw
      cv = 4'd0; cd1 = 64'd0; cd2 = 64'd0;
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 4; k++) begin
            if (cv[k] && !last_gnt[k]) begin
               if ($urandom_range(0, 7) == 0) cv[k] = 1'b0;
            end else begin
               cv[k] = ($urandom_range(0, 1) == 1);
               case ($urandom_range(0, 5))
                  0:       rv = 16'hFFFF;
                  1:       rv = 16'd0;
                  default: rv = 16'($urandom);
               endcase
               cd1[k*16 +: 16] = rv;
               cd2[k*16 +: 16] = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            end
         end
         rr = ($urandom_range(0, 63) == 0);
         drive(cv, cd1, cd2, rr);
      end
      repeat (4) drive(4'd0, 64'd0, 64'd0, 1'b0);

      check("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
